// File: rtl/carry_select8.sv
// carry_select8: 8-bit carry-select adder with a registered sum and carry-out.
// The lower nibble ripples from ci; the upper nibble is computed twice, once
// with carry-in c_0 and once with c_1, and the lower carry-out picks one copy.
module carry_select8 (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] s,
  output logic       co,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  input  logic       c_0,
  input  logic       c_1
);

  // Ripple carry chains: index 0 is the block carry-in, index 4 the carry-out.
  logic [4:0] w_c_lo;
  logic [4:0] w_c_up0;
  logic [4:0] w_c_up1;

  logic [3:0] w_s_lo;
  logic [3:0] w_u0;
  logic [3:0] w_u1;

  logic [3:0] w_s_hi;
  logic       w_co_n;

  assign w_c_lo[0]  = ci;
  assign w_c_up0[0] = c_0;
  assign w_c_up1[0] = c_1;

  // Four full adders per block; the two upper copies share operands and
  // differ only in their speculative carry-in.
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign w_s_lo[g]     = a[g] ^ b[g] ^ w_c_lo[g];
    assign w_c_lo[g+1]   = (a[g] & b[g]) | (w_c_lo[g] & (a[g] ^ b[g]));

    assign w_u0[g]       = a[g+4] ^ b[g+4] ^ w_c_up0[g];
    assign w_c_up0[g+1]  = (a[g+4] & b[g+4]) | (w_c_up0[g] & (a[g+4] ^ b[g+4]));

    assign w_u1[g]       = a[g+4] ^ b[g+4] ^ w_c_up1[g];
    assign w_c_up1[g+1]  = (a[g+4] & b[g+4]) | (w_c_up1[g] & (a[g+4] ^ b[g+4]));
  end

  // Lower carry-out selects the upper copy; no correction for odd c_0/c_1 ties.
  assign {w_co_n, w_s_hi} = w_c_lo[4] ? {w_c_up1[4], w_u1} : {w_c_up0[4], w_u0};

  logic [7:0] r_s;
  logic       r_co;

  // Output register: one-cycle latency, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s  <= 8'h00;
      r_co <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge
      // values, so ordering between sequential blocks cannot change results.
      r_s  <= {w_s_hi, w_s_lo};
      r_co <= w_co_n;
    end
  end

  assign s  = r_s;
  assign co = r_co;

endmodule

// File: tb/tb_carry_select8.sv
// tb_carry_select8: directed self-checking bench for carry_select8.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge that registers them.
`timescale 1ns/1ps
module tb_carry_select8;

  logic       clk;
  logic       rst_n;
  logic [7:0] s;
  logic       co;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic       c_0;
  logic       c_1;

  int checks;
  int errors;

  carry_select8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s),
    .co    (co),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .c_0   (c_0),
    .c_1   (c_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operand set on the falling edge, then move just past the next
  // rising edge so the registered result is visible.
  task automatic drive(input logic [7:0] ta, input logic [7:0] tb,
                       input logic tci, input logic tc0, input logic tc1);
    @(negedge clk);
    a   = ta;
    b   = tb;
    ci  = tci;
    c_0 = tc0;
    c_1 = tc1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a = 8'd0; b = 8'd0; ci = 1'b0; c_0 = 1'b0; c_1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 8'h00 || co !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: s=%h co=%b, expected s=00 co=0", s, co);
    end
    // Outputs hold at zero across edges while reset is asserted.
    a = 8'd200; b = 8'd100;
    @(posedge clk); #1;
    checks++;
    if (s !== 8'h00 || co !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: s=%h co=%b, expected s=00 co=0", s, co);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Table entries: a, b, ci, expected s, expected co (c_0=0, c_1=1).
  task automatic test_basic();
    logic [7:0] va [10] = '{8'd5,  8'd37, 8'd125, 8'd63,  8'd100, 8'd127, 8'd255, 8'd122, 8'd245, 8'd3};
    logic [7:0] vb [10] = '{8'd10, 8'd48, 8'd110, 8'd211, 8'd200, 8'd127, 8'd255, 8'd11,  8'd2,   8'd90};
    logic       vc [10] = '{1'b1,  1'b0,  1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1};
    logic [7:0] es [10] = '{8'd16, 8'd85, 8'd236, 8'd18,  8'd44,  8'd255, 8'd255, 8'd134, 8'd247, 8'd94};
    logic       ec [10] = '{1'b0,  1'b0,  1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(va[i], vb[i], vc[i], 1'b0, 1'b1);
      checks++;
      if (s !== es[i] || co !== ec[i]) begin
        errors++;
        $display("FAIL basic_%0d (a=%0d b=%0d ci=%b): s=%0d co=%b, expected s=%0d co=%b",
                 i, va[i], vb[i], vc[i], s, co, es[i], ec[i]);
      end
    end
  endtask

  // Back-to-back operands every cycle; each edge must reflect only its own set.
  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'd1,  8'd15, 8'd240, 8'd128};
    logic [7:0] vb [4] = '{8'd1,  8'd1,  8'd16,  8'd128};
    logic       vc [4] = '{1'b0,  1'b0,  1'b0,   1'b1};
    logic [7:0] es [4] = '{8'd2,  8'd16, 8'd0,   8'd1};
    logic       ec [4] = '{1'b0,  1'b0,  1'b1,   1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vc[i], 1'b0, 1'b1);
      checks++;
      if (s !== es[i] || co !== ec[i]) begin
        errors++;
        $display("FAIL b2b_%0d: s=%0d co=%b, expected s=%0d co=%b", i, s, co, es[i], ec[i]);
      end
    end
  endtask

  // Non-standard speculative carries expose the raw select function.
  task automatic test_spec_carries();
    // c4=0 selects copy 0 with c_0=1: upper 0+0+1 -> s=0x10, co=0.
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (s !== 8'h10 || co !== 1'b0) begin
      errors++;
      $display("FAIL spec_c0_sel: s=%h co=%b, expected s=10 co=0", s, co);
    end
    // c4=1 selects copy 1 with c_1=0: upper 0+0+0 -> s=0x00, co=0.
    drive(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0);
    checks++;
    if (s !== 8'h00 || co !== 1'b0) begin
      errors++;
      $display("FAIL spec_c1_sel: s=%h co=%b, expected s=00 co=0", s, co);
    end
    // c4=0, copy 0 with c_0=1: upper F+0+1 -> u0=0, k0=1 -> s=0x0F, co=1.
    drive(8'hF0, 8'h0F, 1'b0, 1'b1, 1'b0);
    checks++;
    if (s !== 8'h0F || co !== 1'b1) begin
      errors++;
      $display("FAIL spec_k0_carry: s=%h co=%b, expected s=0F co=1", s, co);
    end
  endtask

  task automatic test_mid_reset();
    drive(8'd255, 8'd255, 1'b1, 1'b0, 1'b1);
    checks++;
    if (s !== 8'hFF || co !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: s=%h co=%b, expected s=FF co=1", s, co);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 8'h00 || co !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: s=%h co=%b, expected s=00 co=0", s, co);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'd200; b = 8'd100; ci = 1'b0; c_0 = 1'b0; c_1 = 1'b1;
    #1;
    checks++;
    if (s !== 8'h00 || co !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hold: s=%h co=%b, expected s=00 co=0", s, co);
    end
    @(posedge clk); #1;
    checks++;
    if (s !== 8'd44 || co !== 1'b1) begin
      errors++;
      $display("FAIL midrst_first: s=%0d co=%b, expected s=44 co=1", s, co);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_spec_carries();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
